// File: rtl/four_req_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// four_req_rr_arbiter_pkg : shared widths and FSM state type for the arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package four_req_rr_arbiter_pkg;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  // Owner just released becomes lowest priority: scan restarts one past it.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    return id + ID_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/four_req_rr_arbiter_rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4 : combinational rotating-priority picker, first request at or after ptr
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick4
  import four_req_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] win_id,
  output logic [NREQ-1:0] win_oh
);

  logic [ID_W-1:0] w_idx;

  // Scan from the far end back toward ptr so the nearest request wins last.
  always_comb begin
    found  = 1'b0;
    win_id = ptr;
    w_idx  = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = ptr + ID_W'(i);
      if (req[w_idx]) begin
        found  = 1'b1;
        win_id = w_idx;
      end
    end
    win_oh = found ? (NREQ'(1) << win_id) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/four_req_rr_arbiter.sv
// ---------------------------------------------------------------------------
// four_req_rr_arbiter : 4-way round-robin arbiter, registered one-hot grant,
//                       hold-time limit with forced-release timeout pulse
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module four_req_rr_arbiter
  import four_req_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy,
  output logic            any_req,
  output logic            timeout
);

  localparam logic [CNT_W-1:0] c_hold_lim = CNT_W'(HOLD_MAX);

  arb_state_t      r_state, w_state_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [ID_W-1:0] r_gnt_id, w_gnt_id_nxt;
  logic [ID_W-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;
  logic            r_timeout, w_timeout_nxt;

  logic            w_found;
  logic [ID_W-1:0] w_win_id;
  logic [NREQ-1:0] w_win_oh;
  logic            w_owner_req;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .found  (w_found),
    .win_id (w_win_id),
    .win_oh (w_win_oh)
  );

  assign w_owner_req = req[r_gnt_id];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt  = ST_OWN;
          w_gnt_nxt    = w_win_oh;
          w_gnt_id_nxt = w_win_id;
          w_hold_nxt   = CNT_W'(1);
        end
      end
      ST_OWN: begin
        // A voluntary drop on the limit cycle counts as a normal release.
        if (!w_owner_req || (r_hold_cnt == c_hold_lim)) begin
          w_state_nxt   = ST_IDLE;
          w_gnt_nxt     = '0;
          w_ptr_nxt     = next_ptr(r_gnt_id);
          w_hold_nxt    = '0;
          w_timeout_nxt = w_owner_req;
        end else begin
          w_hold_nxt = r_hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign busy    = (r_state == ST_OWN);
  assign any_req = |req;
  assign timeout = r_timeout;

endmodule

`default_nettype wire
